// File: rtl/pipelined_shifter_if.sv
// rtl/pipelined_shifter_if.sv - operand/result handshake bundle for pipelined_shifter
//
// Purpose: groups the operand-side and result-side valid/ready handshakes.
// Ports (signals):
//   in_valid/in_ready            operand handshake
//   in_data/in_count/in_op/in_tag operand payload
//   out_valid/out_ready          result handshake
//   out_data/out_tag/out_illegal result payload
// Modports: slave = the shifter, master = the producer/consumer around it.
interface pipelined_shifter_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    localparam int CW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CW-1:0]    in_count;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport slave (
        input  in_valid, in_data, in_count, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_illegal
    );

    modport master (
        output in_valid, in_data, in_count, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_illegal
    );
endinterface

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - fully pipelined rotate/shift unit, one stage per count bit
//
// Purpose: ROL/SLL/ROR/SRL/SRA on a WIDTH-bit operand with a pass-through tag.
// Stage k shifts by 2^k when count[k] is set; every stage is registered, so
// the result appears CW-1 edges after acceptance when the pipe keeps moving.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   bus        pipelined_shifter_if.slave (operand in, result out)
//   out_carry  last bit shifted out (only with SHIFTER_CARRY_EN defined)
// Optional feature macro: SHIFTER_CARRY_EN
module pipelined_shifter #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic rst,
    pipelined_shifter_if.slave bus
`ifdef SHIFTER_CARRY_EN
    ,
    output logic out_carry
`endif
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_ROR = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [CW-1:0]    count;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
        logic             illegal;
        logic             sign;
`ifdef SHIFTER_CARRY_EN
        logic             carry;
`endif
    } stage_t;

    logic   adv;
    stage_t in_stage;
    stage_t last;

    // A single advance enable for the whole pipe: bubbles are kept, never squeezed.
    assign adv          = ~last.valid | bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        in_stage         = '0;
        in_stage.valid   = bus.in_valid & adv;
        in_stage.data    = bus.in_data;
        in_stage.count   = bus.in_count;
        in_stage.op      = bus.in_op;
        in_stage.tag     = bus.in_tag;
        in_stage.illegal = (bus.in_op > OP_SRA);
        // SRA fill comes from the original operand, not from intermediate data.
        in_stage.sign    = bus.in_data[WIDTH-1];
    end

    for (genvar k = 0; k < CW; k++) begin : g_stage
        localparam int S = 1 << k;

        stage_t src;
        stage_t nxt;
        stage_t q;

        if (k == 0) begin : g_head
            assign src = in_stage;
        end else begin : g_link
            assign src = g_stage[k-1].q;
        end

        always_comb begin
            nxt = src;
            if (src.count[k] && !src.illegal) begin
                case (src.op)
                    OP_ROL:  nxt.data = (src.data << S) | (src.data >> (WIDTH - S));
                    OP_SLL:  nxt.data = src.data << S;
                    OP_ROR:  nxt.data = (src.data >> S) | (src.data << (WIDTH - S));
                    OP_SRL:  nxt.data = src.data >> S;
                    OP_SRA:  nxt.data = (src.data >> S) | ({WIDTH{src.sign}} << (WIDTH - S));
                    default: nxt.data = src.data;
                endcase
`ifdef SHIFTER_CARRY_EN
                // Left moves lose bit WIDTH-S, right moves lose bit S-1; a
                // rotate's carry is the bit that wrapped.
                nxt.carry = (src.op == OP_ROL || src.op == OP_SLL) ? src.data[WIDTH-S]
                                                                   : src.data[S-1];
`endif
            end
            // Empty slots carry zero payload so idle outputs read 0.
            if (!src.valid) begin
                nxt = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else if (adv) begin
                q <= nxt;
            end
        end
    end

    assign last            = g_stage[CW-1].q;
    assign bus.out_valid   = last.valid;
    assign bus.out_data    = last.data;
    assign bus.out_tag     = last.tag;
    assign bus.out_illegal = last.illegal;
`ifdef SHIFTER_CARRY_EN
    assign out_carry       = last.carry;
`endif

    // Control fields have no consumer after the final stage.
    logic unused_last;
    assign unused_last = &{1'b0, last.count, last.op, last.sign};
endmodule
